// File: rtl/pwm_multi.sv
// Multi-channel PWM slave: one shared up-counter with programmable period,
// per-channel duty/enable/polarity, period and duty double-buffered to the wrap.
module pwm_multi #(
  parameter int          CHANNELS  = 4,
  parameter int          CNT_WIDTH = 8,
  parameter logic [31:0] BASE_ADDR = 32'h8000_0000
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                wr_en_i,
  input  logic                rd_en_i,
  input  logic [31:0]         address_i,
  input  logic [31:0]         wr_data_i,
  output logic [31:0]         rd_data_o,
  output logic                ready_o,
  output logic                error_o,
  output logic [CHANNELS-1:0] pwm_out_o,
  output logic                period_irq_o
);

  localparam logic [7:0] OFF_CTRL   = 8'h00;
  localparam logic [7:0] OFF_PERIOD = 8'h04;
  localparam logic [7:0] OFF_COUNT  = 8'h08;
  localparam logic [7:0] OFF_DUTY0  = 8'h10;

  logic                 run_q, run_d;
  logic [CHANNELS-1:0]  en_q, en_d;
  logic [CHANNELS-1:0]  pol_q, pol_d;
  logic [CNT_WIDTH-1:0] period_q, period_d;
  logic [CNT_WIDTH-1:0] duty_q [CHANNELS];
  logic [CNT_WIDTH-1:0] duty_d [CHANNELS];
  logic [CNT_WIDTH-1:0] period_act_q, period_act_d;
  logic [CNT_WIDTH-1:0] duty_act_q [CHANNELS];
  logic [CNT_WIDTH-1:0] duty_act_d [CHANNELS];
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic [CHANNELS-1:0]  pwm_q, pwm_d;
  logic                 irq_q, irq_d;
  logic                 err_q, err_d;
  logic [31:0]          rd_data_q, rd_data_d;

  logic                 sel, wr_acc, rd_acc, mapped, wrap, load;
  logic [7:0]           off;
  logic [CHANNELS-1:0]  duty_hit;
  logic                 unused_wr_bits;

  assign unused_wr_bits = ^wr_data_i;

  always_comb begin
    sel    = (address_i[31:8] == BASE_ADDR[31:8]);
    off    = address_i[7:0];
    wr_acc = sel && wr_en_i && !rd_en_i;
    rd_acc = sel && rd_en_i && !wr_en_i;
    for (int i = 0; i < CHANNELS; i++) begin
      duty_hit[i] = (off == OFF_DUTY0 + 8'(4 * i));
    end
    mapped = (off == OFF_CTRL) || (off == OFF_PERIOD) || (off == OFF_COUNT) || (|duty_hit);
    err_d  = sel && ((wr_en_i && rd_en_i) || ((wr_acc || rd_acc) && !mapped) ||
                     (wr_acc && off == OFF_COUNT));
  end

  // Register file writes
  always_comb begin
    run_d    = run_q;
    en_d     = en_q;
    pol_d    = pol_q;
    period_d = period_q;
    duty_d   = duty_q;
    if (wr_acc && off == OFF_CTRL) begin
      en_d  = wr_data_i[CHANNELS-1:0];
      pol_d = wr_data_i[16 +: CHANNELS];
      run_d = wr_data_i[31];
    end
    if (wr_acc && off == OFF_PERIOD) period_d = wr_data_i[CNT_WIDTH-1:0];
    for (int i = 0; i < CHANNELS; i++) begin
      if (wr_acc && duty_hit[i]) duty_d[i] = wr_data_i[CNT_WIDTH-1:0];
    end
  end

  // Shadows take the post-write value so a write in the wrap cycle is not lost.
  always_comb begin
    wrap         = run_q && (cnt_q == period_act_q);
    load         = !run_q || wrap;
    period_act_d = load ? period_d : period_act_q;
    for (int i = 0; i < CHANNELS; i++) begin
      duty_act_d[i] = load ? duty_d[i] : duty_act_q[i];
    end
    if (!run_q || wrap) cnt_d = '0;
    else                cnt_d = cnt_q + CNT_WIDTH'(1);
    irq_d = wrap;
    for (int i = 0; i < CHANNELS; i++) begin
      pwm_d[i] = (run_q && en_q[i] && (cnt_q < duty_act_q[i])) ^ pol_q[i];
    end
  end

  always_comb begin
    rd_data_d = rd_data_q;
    if (rd_acc) begin
      if (off == OFF_CTRL) begin
        rd_data_d                 = '0;
        rd_data_d[CHANNELS-1:0]   = en_q;
        rd_data_d[16 +: CHANNELS] = pol_q;
        rd_data_d[31]             = run_q;
      end
      if (off == OFF_PERIOD) rd_data_d = 32'(period_q);
      if (off == OFF_COUNT)  rd_data_d = 32'(cnt_q);
      for (int i = 0; i < CHANNELS; i++) begin
        if (duty_hit[i]) rd_data_d = 32'(duty_q[i]);
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      run_q        <= 1'b0;
      en_q         <= '0;
      pol_q        <= '0;
      period_q     <= '1;
      period_act_q <= '1;
      cnt_q        <= '0;
      pwm_q        <= '0;
      irq_q        <= 1'b0;
      err_q        <= 1'b0;
      rd_data_q    <= '0;
      for (int i = 0; i < CHANNELS; i++) begin
        duty_q[i]     <= '0;
        duty_act_q[i] <= '0;
      end
    end else begin
      run_q        <= run_d;
      en_q         <= en_d;
      pol_q        <= pol_d;
      period_q     <= period_d;
      period_act_q <= period_act_d;
      cnt_q        <= cnt_d;
      pwm_q        <= pwm_d;
      irq_q        <= irq_d;
      err_q        <= err_d;
      rd_data_q    <= rd_data_d;
      for (int i = 0; i < CHANNELS; i++) begin
        duty_q[i]     <= duty_d[i];
        duty_act_q[i] <= duty_act_d[i];
      end
    end
  end

  assign ready_o      = 1'b1;
  assign rd_data_o    = rd_data_q;
  assign error_o      = err_q;
  assign pwm_out_o    = pwm_q;
  assign period_irq_o = irq_q;

endmodule
